// File: rtl/i2s_pkg.sv
// i2s_pkg: types shared by the I2S transmitter, the mixer and test harnesses.
//   I2sMode : frame alignment, Philips I2S (LRCLK leads MSB by one BCLK)
//             or left-justified (LRCLK edge coincides with the MSB).
package i2s_pkg;

  typedef enum logic {
    I2S_STANDARD,
    I2S_LEFT_JUSTIFIED
  } I2sMode;

endpackage

// File: rtl/i2s_clock_divider.sv
// i2s_clock_divider: derives the bit clock from the system clock as a plain
// register (no new clock domain) plus a one-cycle enable marking BCLK falls.
//   clk      in  : system clock
//   rst      in  : synchronous active-high reset (div=0, bclk=0)
//   bclk     out : registered bit clock, period 2*BCLK_HALF clk cycles
//   fallTick out : high in the cycle whose clk edge drives bclk 1->0
module i2s_clock_divider #(
  parameter int BCLK_HALF = 49
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fallTick
);

  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);

  logic [DW-1:0] div;
  logic          terminal;

  assign terminal = (div == DIV_LAST);
  // Combinational so the consumer registers its data on the very edge
  // that drops bclk, keeping data and clock edges aligned.
  assign fallTick = terminal & bclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (terminal) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + DW'(1);
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: stereo I2S / left-justified serializer.
// Sample pairs enter through a valid/ready handshake into a one-entry
// holding register; at each frame boundary the pair moves into the frame
// registers and is shifted out MSB first, left slot then right slot.
//   clk          in  : system clock (only clock)
//   rst          in  : synchronous active-high reset, aborts current frame
//   i_left       in  : left sample, two's complement
//   i_right      in  : right sample
//   i_valid      in  : sample pair offered
//   o_ready      out : holding register empty
//   o_bclk       out : bit clock
//   o_lrclk      out : word select, 0 = left, 1 = right
//   o_din        out : serial data, MSB first, zero padded to SLOT_WIDTH
//   o_frameStart out : one-cycle pulse on every frame load
//   o_underrun   out : one-cycle pulse when a load found no data
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int     SAMPLE_WIDTH  = 16,
  parameter int     SLOT_WIDTH    = 16,
  parameter int     BCLK_HALF     = 49,
  parameter I2sMode MODE          = I2S_STANDARD,
  parameter int     UNDERRUN_ZERO = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] i_left,
  input  logic [SAMPLE_WIDTH-1:0] i_right,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic                    o_bclk,
  output logic                    o_lrclk,
  output logic                    o_din,
  output logic                    o_frameStart,
  output logic                    o_underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST_POS = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] SLOT_POS = CW'(SLOT_WIDTH);
  localparam bit LJ = (MODE == I2S_LEFT_JUSTIFIED);

  logic                    bclk;
  logic                    fallTick;
  logic [CW-1:0]           bitCount;
  logic [CW-1:0]           nb;
  logic [CW-1:0]           nbAhead;
  logic [CW-1:0]           slotK;
  logic                    slotSel;
  logic                    loadEvt;
  logic                    holdFull;
  logic [SAMPLE_WIDTH-1:0] holdL, holdR;
  logic [SAMPLE_WIDTH-1:0] frameL, frameR;
  logic [SAMPLE_WIDTH-1:0] frameLNext, frameRNext;
  logic [SAMPLE_WIDTH-1:0] slotSample;
  logic                    dinNext;
  logic                    lrNext;
  logic                    underrunNext;
  logic                    dinR, lrR, frameStartR, underrunR;

  i2s_clock_divider #(.BCLK_HALF(BCLK_HALF)) uDiv (
    .clk      (clk),
    .rst      (rst),
    .bclk     (bclk),
    .fallTick (fallTick)
  );

  always_comb begin
    nb           = (bitCount == LAST_POS) ? '0 : bitCount + CW'(1);
    // I2S drives word select for the position one bit ahead.
    nbAhead      = (nb == LAST_POS) ? '0 : nb + CW'(1);
    loadEvt      = fallTick && (nb == '0);
    frameLNext   = frameL;
    frameRNext   = frameR;
    underrunNext = 1'b0;
    if (loadEvt) begin
      if (holdFull) begin
        frameLNext = holdL;
        frameRNext = holdR;
      end else if (i_valid) begin
        // Empty holding register: the offered pair goes straight out.
        frameLNext = i_left;
        frameRNext = i_right;
      end else begin
        underrunNext = 1'b1;
        if (UNDERRUN_ZERO != 0) begin
          frameLNext = '0;
          frameRNext = '0;
        end
      end
    end
    // Bit select uses the post-load frame so the MSB leaves on the load edge.
    slotSel    = (nb >= SLOT_POS);
    slotK      = slotSel ? nb - SLOT_POS : nb;
    slotSample = slotSel ? frameRNext : frameLNext;
    dinNext    = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (int'(slotK) == i) dinNext = slotSample[SAMPLE_WIDTH-1-i];
    end
    lrNext = LJ ? slotSel : (nbAhead >= SLOT_POS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitCount    <= LAST_POS;
      dinR        <= 1'b0;
      lrR         <= LJ;
      frameL      <= '0;
      frameR      <= '0;
      holdFull    <= 1'b0;
      holdL       <= '0;
      holdR       <= '0;
      frameStartR <= 1'b0;
      underrunR   <= 1'b0;
    end else begin
      frameStartR <= loadEvt;
      underrunR   <= underrunNext;
      if (fallTick) begin
        bitCount <= nb;
        dinR     <= dinNext;
        lrR      <= lrNext;
        frameL   <= frameLNext;
        frameR   <= frameRNext;
      end
      if (loadEvt && holdFull) begin
        holdFull <= 1'b0;
      end else if (i_valid && !holdFull && !loadEvt) begin
        holdFull <= 1'b1;
        holdL    <= i_left;
        holdR    <= i_right;
      end
    end
  end

  assign o_ready      = ~holdFull;
  assign o_bclk       = bclk;
  assign o_lrclk      = lrR;
  assign o_din        = dinR;
  assign o_frameStart = frameStartR;
  assign o_underrun   = underrunR;

endmodule
